// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC selection with CP0 redirects overriding stalls,
// instruction-address fault flag, one-fetch redirect marker and fetch/stall counters.
module pc_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        CNT_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0]  EXC_PC   = ADDR_W'(32'h0000_4180),
    parameter logic [ADDR_W-1:0]  IMEM_LO  = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0]  IMEM_HI  = ADDR_W'(32'h0000_6ffc)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic [1:0]        PCsrc,
    input  logic              Branch,
    input  logic [ADDR_W-1:0] NPC,
    input  logic [ADDR_W-1:0] j_r,
    input  logic              Req,
    input  logic              Eret,
    input  logic [ADDR_W-1:0] EPC,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC4,
    output logic              ExcAdEL,
    output logic              Redir,
    output logic [1:0]        State,
    output logic [CNT_W-1:0]  FetchCnt,
    output logic [CNT_W-1:0]  StallCnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_REDIR = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                redirect;
    logic                load;
    logic [ADDR_W-1:0]   pc_plus4;

    assign redirect = Req | Eret;
    assign load     = redirect | En;
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Next-PC selection: redirects beat the stall, Req beats Eret.
    always_comb begin
        pc_d = pc_q;
        if (Req) begin
            pc_d = EXC_PC;
        end else if (Eret) begin
            pc_d = EPC;
        end else if (En) begin
            case (PCsrc)
                2'b00:   pc_d = pc_plus4;
                2'b01:   pc_d = NPC;
                2'b10:   pc_d = j_r;
                2'b11:   pc_d = Branch ? NPC : pc_plus4;
                default: pc_d = pc_plus4;
            endcase
        end
    end

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect first, then stall, otherwise run.
    always_comb begin
        state_d = ST_RUN;
        if (redirect) begin
            state_d = ST_REDIR;
        end else if (!En) begin
            state_d = ST_STALL;
        end
    end

    // FSM outputs.
    always_comb begin
        Redir = 1'b0;
        State = state_q;
        if (state_q == ST_REDIR) begin
            Redir = 1'b1;
        end
    end

    assign PC       = pc_q;
    assign PC4      = pc_plus4;
    assign FetchCnt = fetch_cnt_q;
    assign StallCnt = stall_cnt_q;
    assign ExcAdEL  = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios from the test plan plus a randomized run
// against a sequential reference model of the next-PC rules.
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        En;
    logic [1:0]  PCsrc;
    logic        Branch;
    logic [31:0] NPC;
    logic [31:0] j_r;
    logic        Req;
    logic        Eret;
    logic [31:0] EPC;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        ExcAdEL;
    logic        Redir;
    logic [1:0]  State;
    logic [31:0] FetchCnt;
    logic [31:0] StallCnt;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_fc;
    logic [31:0] m_sc;
    logic [1:0]  m_st;

    pc_unit dut (
        .Clk(Clk), .Reset(Reset), .En(En), .PCsrc(PCsrc), .Branch(Branch),
        .NPC(NPC), .j_r(j_r), .Req(Req), .Eret(Eret), .EPC(EPC),
        .PC(PC), .PC4(PC4), .ExcAdEL(ExcAdEL), .Redir(Redir), .State(State),
        .FetchCnt(FetchCnt), .StallCnt(StallCnt)
    );

    always #5 Clk = ~Clk;

    function automatic logic m_adel(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6ffc);
    endfunction

    task automatic assert_reset();
        Reset = 1'b1;
        En = 1'b0; PCsrc = 2'b00; Branch = 1'b0; NPC = '0; j_r = '0;
        Req = 1'b0; Eret = 1'b0; EPC = '0;
        #2;
        m_pc = 32'h3000; m_fc = 0; m_sc = 0; m_st = 2'b00;
    endtask

    task automatic release_reset();
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    // Apply one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input logic en, input logic [1:0] src, input logic br,
                        input logic [31:0] npc, input logic [31:0] jr,
                        input logic req, input logic eret, input logic [31:0] epc);
        En = en; PCsrc = src; Branch = br; NPC = npc; j_r = jr;
        Req = req; Eret = eret; EPC = epc;
        @(posedge Clk);
        if (req)       m_pc = 32'h4180;
        else if (eret) m_pc = epc;
        else if (en) begin
            if (src == 2'd1 || (src == 2'd3 && br)) m_pc = npc;
            else if (src == 2'd2)                   m_pc = jr;
            else                                    m_pc = m_pc + 4;
        end
        if (req || eret || en) m_fc = m_fc + 1;
        else                   m_sc = m_sc + 1;
        m_st = (req || eret) ? 2'd2 : (!en ? 2'd1 : 2'd0);
        #1;
        Req = 1'b0; Eret = 1'b0;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        assert_reset();
        total++; if (PC !== 32'h3000) $display("FAIL reset_pc got %h want %h", PC, 32'h3000); else passed++;
        total++; if (PC4 !== 32'h3004) $display("FAIL reset_pc4 got %h want %h", PC4, 32'h3004); else passed++;
        total++; if (State !== 2'b00 || Redir !== 1'b0) $display("FAIL reset_state got %b/%b want 00/0", State, Redir); else passed++;
        total++; if (FetchCnt !== 0 || StallCnt !== 0) $display("FAIL reset_cnt got %0d/%0d want 0/0", FetchCnt, StallCnt); else passed++;
        total++; if (ExcAdEL !== 1'b0) $display("FAIL reset_adel got %b want 0", ExcAdEL); else passed++;
        release_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
        assert_reset(); release_reset();
        total++; if (PC !== 32'h3000) $display("FAIL seq_start got %h want %h", PC, 32'h3000); else passed++;
        for (int i = 0; i < 3; i++) begin
            adv(1);
            total++; if (PC !== exp_pc[i]) $display("FAIL seq_pc%0d got %h want %h", i, PC, exp_pc[i]); else passed++;
        end
        total++; if (FetchCnt !== 32'd3) $display("FAIL seq_fetchcnt got %0d want 3", FetchCnt); else passed++;
        total++; if (State !== 2'b00) $display("FAIL seq_state got %b want 00", State); else passed++;
    endtask

    task automatic test_branch();
        logic [1:0]  src [4];
        logic        br  [4];
        logic [31:0] exp [4];
        src[0] = 2'b11; br[0] = 1'b0; exp[0] = 32'h3014;
        src[1] = 2'b11; br[1] = 1'b1; exp[1] = 32'h3100;
        src[2] = 2'b01; br[2] = 1'b0; exp[2] = 32'h3100;
        src[3] = 2'b10; br[3] = 1'b0; exp[3] = 32'h3200;
        for (int i = 0; i < 4; i++) begin
            assert_reset(); release_reset();
            adv(4);
            step(1'b1, src[i], br[i], 32'h3100, 32'h3200, 1'b0, 1'b0, 0);
            total++; if (PC !== exp[i]) $display("FAIL branch_case%0d got %h want %h", i, PC, exp[i]); else passed++;
        end
    endtask

    task automatic test_stall();
        assert_reset(); release_reset();
        adv(8);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 1'b0, 32'h5000, 0, 1'b0, 1'b0, 0);
        total++; if (PC !== 32'h3020) $display("FAIL stall_pc got %h want %h", PC, 32'h3020); else passed++;
        total++; if (StallCnt !== 32'd4) $display("FAIL stall_cnt got %0d want 4", StallCnt); else passed++;
        total++; if (State !== 2'b01) $display("FAIL stall_state got %b want 01", State); else passed++;
        adv(1);
        total++; if (PC !== 32'h3024 || State !== 2'b00) $display("FAIL stall_resume got %h/%b want 00003024/00", PC, State); else passed++;
        total++; if (FetchCnt !== 32'd9) $display("FAIL stall_fetchcnt got %0d want 9", FetchCnt); else passed++;
    endtask

    task automatic test_redirect();
        assert_reset(); release_reset();
        adv(2);
        step(1'b0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        step(1'b0, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0, 0);
        total++; if (PC !== 32'h4180) $display("FAIL redir_req_pc got %h want %h", PC, 32'h4180); else passed++;
        total++; if (Redir !== 1'b1 || State !== 2'b10) $display("FAIL redir_marker got %b/%b want 1/10", Redir, State); else passed++;
        adv(1);
        total++; if (Redir !== 1'b0 || PC !== 32'h4184) $display("FAIL redir_one_cycle got %b/%h want 0/00004184", Redir, PC); else passed++;
        step(1'b1, 2'b01, 1'b0, 32'h3500, 0, 1'b1, 1'b1, 32'h3040);
        total++; if (PC !== 32'h4180) $display("FAIL redir_both got %h want %h", PC, 32'h4180); else passed++;
        step(1'b0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b1, 32'h3040);
        total++; if (PC !== 32'h3040 || Redir !== 1'b1) $display("FAIL redir_eret got %h/%b want 00003040/1", PC, Redir); else passed++;
        step(1'b0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (State !== 2'b01 || PC !== 32'h3040) $display("FAIL redir_to_stall got %b/%h want 01/00003040", State, PC); else passed++;
        total++; if (FetchCnt !== m_fc || StallCnt !== m_sc) $display("FAIL redir_cnt got %0d/%0d want %0d/%0d", FetchCnt, StallCnt, m_fc, m_sc); else passed++;
    endtask

    task automatic test_adel();
        assert_reset(); release_reset();
        step(1'b1, 2'b10, 1'b0, 0, 32'h3202, 1'b0, 1'b0, 0);
        total++; if (PC !== 32'h3202 || ExcAdEL !== 1'b1) $display("FAIL adel_misalign got %h/%b want 00003202/1", PC, ExcAdEL); else passed++;
        total++; if (PC4 !== 32'h3206) $display("FAIL adel_pc4 got %h want %h", PC4, 32'h3206); else passed++;
        step(1'b1, 2'b01, 1'b0, 32'h7000, 0, 1'b0, 1'b0, 0);
        total++; if (ExcAdEL !== 1'b1) $display("FAIL adel_above got %b want 1", ExcAdEL); else passed++;
        step(1'b1, 2'b01, 1'b0, 32'h6ffc, 0, 1'b0, 1'b0, 0);
        total++; if (ExcAdEL !== 1'b0) $display("FAIL adel_top got %b want 0", ExcAdEL); else passed++;
        step(1'b1, 2'b01, 1'b0, 32'h2ffc, 0, 1'b0, 1'b0, 0);
        total++; if (ExcAdEL !== 1'b1) $display("FAIL adel_below got %b want 1", ExcAdEL); else passed++;
        step(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFC, 0, 1'b0, 1'b0, 0);
        total++; if (PC4 !== 32'h0) $display("FAIL pc4_wrap got %h want 00000000", PC4); else passed++;
        adv(1);
        total++; if (PC !== 32'h0 || ExcAdEL !== 1'b1) $display("FAIL pc_wrap got %h/%b want 00000000/1", PC, ExcAdEL); else passed++;
    endtask

    task automatic test_async_reset();
        assert_reset(); release_reset();
        step(1'b1, 2'b01, 1'b0, 32'h3100, 0, 1'b0, 1'b0, 0);
        step(1'b0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        step(1'b0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (PC !== 32'h3100 || StallCnt !== 32'd2) $display("FAIL areset_pre got %h/%0d want 00003100/2", PC, StallCnt); else passed++;
        #2 Reset = 1'b1;
        #1;
        total++; if (PC !== 32'h3000 || FetchCnt !== 0 || StallCnt !== 0) $display("FAIL areset_stall got %h/%0d/%0d want 00003000/0/0", PC, FetchCnt, StallCnt); else passed++;
        release_reset();
        m_pc = 32'h3000; m_fc = 0; m_sc = 0; m_st = 2'b00;
        step(1'b0, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0, 0);
        #2 Reset = 1'b1;
        #1;
        total++; if (State !== 2'b00 || Redir !== 1'b0 || PC !== 32'h3000) $display("FAIL areset_redir got %b/%b/%h want 00/0/00003000", State, Redir, PC); else passed++;
        release_reset();
    endtask

    task automatic test_random();
        logic        en, br, req, eret;
        logic [1:0]  src;
        logic [31:0] npc, jr, epc;
        assert_reset(); release_reset();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            src  = 2'($urandom_range(0, 3));
            br   = 1'($urandom_range(0, 1));
            req  = ($urandom_range(0, 15) == 0);
            eret = ($urandom_range(0, 11) == 0);
            npc  = 32'h2ff0 + (32'($urandom_range(0, 4100)) << 2) + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
            jr   = 32'h3000 + (32'($urandom_range(0, 4200)) << 2) + 32'($urandom_range(0, 1));
            epc  = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
            step(en, src, br, npc, jr, req, eret, epc);
            total++; if (PC !== m_pc) $display("FAIL rand_pc[%0d] got %h want %h", i, PC, m_pc); else passed++;
            total++; if (PC4 !== m_pc + 32'd4 || ExcAdEL !== m_adel(m_pc)) $display("FAIL rand_pc4_adel[%0d] got %h/%b want %h/%b", i, PC4, ExcAdEL, m_pc + 32'd4, m_adel(m_pc)); else passed++;
            total++; if (State !== m_st || Redir !== (m_st == 2'd2)) $display("FAIL rand_state[%0d] got %b/%b want %b/%b", i, State, Redir, m_st, m_st == 2'd2); else passed++;
            total++; if (FetchCnt !== m_fc || StallCnt !== m_sc) $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, FetchCnt, StallCnt, m_fc, m_sc); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_redirect();
        test_adel();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter for the pipelined MIPS core. It replaces the fixed 32-bit PC register and adds:
- exception entry and `eret` return redirects that override pipeline stalls;
- instruction-address fault detection (AdEL);
- a one-fetch redirect marker;
- fetch and stall performance counters.

It sits in F, drives the instruction-memory address, and takes its control-transfer selection from D and its redirects from M/CP0.

## Interface
Parameters:
- ADDR_W, 32: PC width (≥ 16).
- CNT_W, 32: performance counter width.
- RESET_PC, 32'h0000_3000: PC value after reset.
- EXC_PC, 32'h0000_4180: exception/interrupt handler entry.
- IMEM_LO, 32'h0000_3000: lowest legal fetch address.
- IMEM_HI, 32'h0000_6ffc: highest legal fetch address (inclusive).

Ports:
- Clk  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- En  in  1  1 = PC may advance; 0 = stall (hold PC).
- PCsrc  in  2  00 = PC+4, 01 = jump (NPC), 10 = jr (j_r), 11 = conditional branch.
- Branch  in  1  branch taken; used only when PCsrc = 11.
- NPC  in  ADDR_W  jump/branch target from D.
- j_r  in  ADDR_W  register jump target from D.
- Req  in  1  exception/interrupt redirect from CP0.
- Eret  in  1  `eret` in M; return to EPC.
- EPC  in  ADDR_W  return address from CP0.
- PC  out  ADDR_W  current fetch address.
- PC4  out  ADDR_W  PC + 4.
- ExcAdEL  out  1  current PC is misaligned or outside [IMEM_LO, IMEM_HI].
- Redir  out  1  current PC was loaded by a Req/Eret redirect.
- State  out  2  00 = RUN, 01 = STALL, 10 = REDIR.
- FetchCnt  out  CNT_W  count of PC advances.
- StallCnt  out  CNT_W  count of stalled cycles.

## Operation
Next-PC selection. Priority, highest first:
1. Req → EXC_PC.
2. Eret → EPC.
3. En = 0 → hold PC.
4. PCsrc: 00 → PC4; 01 → NPC; 10 → j_r; 11 → NPC if Branch = 1, else PC4.

Rules:
- Req and Eret ignore En: a redirect always loads, even during a stall.
- If Req and Eret are both asserted, Req wins.
- PC4 = PC + 4, modulo 2^ADDR_W. 0xFFFF_FFFC + 4 wraps to 0.
- ExcAdEL is combinational from PC: (PC[1:0] ≠ 0) OR (PC < IMEM_LO) OR (PC > IMEM_HI), using unsigned compares.
- An illegal target is still loaded as the PC. The fault is reported through ExcAdEL only; this block never redirects itself.

FSM, evaluated every edge, redirect checked first:
- Any state: Req or Eret → REDIR.
- Otherwise, En = 0 → STALL.
- Otherwise, En = 1 → RUN.
- REDIR lasts exactly one cycle unless another redirect arrives, or the pipeline stalls (→ STALL).
- Redir = 1 iff State = REDIR.

Counters:
- FetchCnt increments on every edge where PC loads a new value, whether from a redirect or from an advance with En = 1.
- StallCnt increments on every edge where PC holds (En = 0, no redirect).
- Both counters wrap modulo 2^CNT_W.

## Timing
Reset values while Reset = 1 (asynchronous):
- PC = RESET_PC, PC4 = RESET_PC + 4.
- State = RUN, Redir = 0.
- FetchCnt = StallCnt = 0.
- ExcAdEL = 0 for the default parameters.

Latency and hold behaviour:
- Single-cycle: inputs sampled at edge k appear on PC at edge k.
- Redir is high for the cycle after the redirect edge.
- PC4 and ExcAdEL follow PC combinationally, same cycle.
- Inputs are don't-care while Reset = 1.
- Reset asserted mid-stall or mid-redirect clears everything immediately, with no wait for a clock edge.
- Reset deassert is synchronous to Clk in the system; the first advance occurs at the first edge with Reset = 0.

## Test plan
- Reset/sequential: release Reset, En = 1, PCsrc = 00 for 3 edges → PC = 0x3000, 0x3004, 0x3008, 0x300C; FetchCnt = 3; State = RUN.
- Branch/jump/jr at PC 0x3010, NPC = 0x3100, j_r = 0x3200:
  - PCsrc = 11, Branch = 0 → 0x3014.
  - PCsrc = 11, Branch = 1 → 0x3100.
  - PCsrc = 01 → 0x3100.
  - PCsrc = 10 → 0x3200.
- Stall: En = 0 for 4 edges at PC 0x3020 → PC stays 0x3020, StallCnt = 4, State = STALL. Then En = 1 → PC 0x3024, State = RUN.
- Redirect priority:
  - During En = 0, pulse Req → PC = 0x4180, Redir = 1 for one cycle.
  - Req and Eret together with EPC = 0x3040 → PC = 0x4180.
  - Eret alone → PC = 0x3040.
- AdEL:
  - j_r = 0x3202 via PCsrc = 10 → PC = 0x3202, ExcAdEL = 1.
  - NPC = 0x7000 → ExcAdEL = 1.
  - NPC = 0x6ffc → ExcAdEL = 0.
- Async reset mid-operation: assert Reset between edges while PC = 0x3100 and StallCnt = 2 → PC = 0x3000 and counters = 0 before the next edge.
